// File: rtl/tlul_pkg.sv
// TL-UL request/response structures shared by the SRAM port-A path.
// Data/mask fields are sized for the widest supported bus (64-bit); narrower buses use the low lanes.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_user_cap;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [63:0] d_data;
    logic        d_user_cap;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/sram_zeroizer.sv
// Zeroes a word range of the SRAM through TL-UL port A, clearing capability tags,
// and forwards the core's data-side traffic unchanged between runs.
module sram_zeroizer
  import tlul_pkg::*;
#(
  parameter int unsigned AddrWidth      = 17,
  parameter int unsigned DataWidth      = 32,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter logic [7:0]  ZeroSource     = 8'hFF,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [AddrWidth-1:0] len_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  tl_h2d_t              tl_h_i,
  output tl_d2h_t              tl_h_o,
  output tl_h2d_t              tl_d_o,
  input  tl_d2h_t              tl_d_i
);

  localparam int unsigned Bytes = DataWidth / 8;
  localparam int unsigned Shift = $clog2(Bytes);
  localparam int unsigned PtrW  = AddrWidth - Shift;
  localparam int unsigned OutW  = 3;
  localparam int unsigned UpW   = 8;
  localparam logic [7:0]  GenMask = 8'((16'd1 << Bytes) - 16'd1);

  typedef enum logic [2:0] {StIdle, StDrain, StZero, StFlush, StDone} state_e;

  state_e               state_q, state_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [AddrWidth-1:0] rem_q, rem_d;
  logic [OutW-1:0]      gen_out_q, gen_out_d;
  logic [UpW-1:0]       up_out_q, up_out_d;
  logic                 err_q, err_d;

  logic                 d_is_gen, gen_d_hs, up_d_hs, up_a_hs;
  logic                 gen_a_valid, gen_a_hs, accept;
  logic [AddrWidth-1:0] gen_off;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^start_addr_i[Shift-1:0];

  // Responses tagged with ZeroSource belong to us, including stale ones after a reset.
  assign d_is_gen    = (tl_d_i.d_source == ZeroSource);
  assign gen_d_hs    = tl_d_i.d_valid & d_is_gen;
  assign up_d_hs     = tl_d_i.d_valid & ~d_is_gen & tl_h_i.d_ready;
  assign up_a_hs     = (state_q == StIdle) & tl_h_i.a_valid & tl_d_i.a_ready;
  assign gen_a_valid = (state_q == StZero) & (rem_q != '0) &
                       (gen_out_q < OutW'(MaxOutstanding));
  assign gen_a_hs    = gen_a_valid & tl_d_i.a_ready;
  assign accept      = start_i & ((state_q == StIdle) | (state_q == StDone));
  assign gen_off     = {ptr_q, {Shift{1'b0}}};

  always_comb begin
    tl_h_o         = tl_d_i;
    tl_h_o.d_valid = tl_d_i.d_valid & ~d_is_gen;
    tl_h_o.a_ready = (state_q == StIdle) & tl_d_i.a_ready;

    tl_d_o         = tl_h_i;
    tl_d_o.d_ready = d_is_gen | tl_h_i.d_ready;
    if (state_q != StIdle) begin
      tl_d_o.a_valid    = gen_a_valid;
      tl_d_o.a_opcode   = PutFullData;
      tl_d_o.a_param    = 3'h0;
      tl_d_o.a_size     = 3'(Shift);
      tl_d_o.a_source   = ZeroSource;
      tl_d_o.a_address  = BaseAddr | 32'(gen_off);
      tl_d_o.a_mask     = GenMask;
      tl_d_o.a_data     = '0;
      tl_d_o.a_user_cap = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    gen_out_d = gen_out_q;
    up_out_d  = up_out_q;
    err_d     = err_q;

    if (up_a_hs && !up_d_hs) begin
      up_out_d = up_out_q + UpW'(1);
    end else if (!up_a_hs && up_d_hs && (up_out_q != '0)) begin
      up_out_d = up_out_q - UpW'(1);
    end

    // Decrements are guarded so a stale response after reset cannot underflow.
    if (gen_a_hs && !(gen_d_hs && (gen_out_q != '0))) begin
      gen_out_d = gen_out_q + OutW'(1);
    end else if (!gen_a_hs && gen_d_hs && (gen_out_q != '0)) begin
      gen_out_d = gen_out_q - OutW'(1);
    end

    if (gen_d_hs && tl_d_i.d_error && (gen_out_q != '0)) begin
      err_d = 1'b1;
    end

    if (gen_a_hs) begin
      ptr_d = ptr_q + PtrW'(1);
      rem_d = rem_q - AddrWidth'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StDrain;
          ptr_d   = start_addr_i[AddrWidth-1:Shift];
          rem_d   = len_words_i;
          err_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (up_out_q == '0) begin
          state_d = (rem_q == '0) ? StDone : StZero;
        end
      end
      StZero: begin
        if (gen_a_hs && (rem_q == AddrWidth'(1))) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (gen_out_d == '0) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      rem_q     <= '0;
      gen_out_q <= '0;
      up_out_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      gen_out_q <= gen_out_d;
      up_out_q  <= up_out_d;
      err_q     <= err_d;
    end
  end

  assign busy_o = (state_q == StDrain) | (state_q == StZero) | (state_q == StFlush);
  assign done_o = (state_q == StDone);
  assign err_o  = err_q;

endmodule

// File: tb/tb_sram_zeroizer.sv
// Directed bench for sram_zeroizer with a one-cycle-latency SRAM model on port A.
module tb_sram_zeroizer;
  import tlul_pkg::*;

  localparam logic [31:0] Base = 32'h0010_0000;
  localparam logic [7:0]  ZSrc = 8'hFF;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [16:0] start_addr_i = '0;
  logic [16:0] len_words_i = '0;
  logic        busy_o, done_o, err_o;
  tl_h2d_t     tl_h_i, tl_d_o;
  tl_d2h_t     tl_h_o, tl_d_i, rsp_q;

  always #5 clk_i = ~clk_i;

  sram_zeroizer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .len_words_i  (len_words_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .tl_h_i       (tl_h_i),
    .tl_h_o       (tl_h_o),
    .tl_d_o       (tl_d_o),
    .tl_d_i       (tl_d_i)
  );

  // SRAM model: always grants, responds the next cycle.
  logic [31:0] mem [32768];
  logic        tag [32768];
  logic [31:0] wlog[$];
  int          wcyc[$];
  int          cyc = 0;
  int          bad_fields = 0;
  int          err_idx = -1;

  always_comb begin
    tl_d_i         = rsp_q;
    tl_d_i.a_ready = 1'b1;
  end

  always @(posedge clk_i) begin
    cyc   <= cyc + 1;
    rsp_q <= '0;
    if (tl_d_o.a_valid) begin
      rsp_q.d_valid  <= 1'b1;
      rsp_q.d_source <= tl_d_o.a_source;
      rsp_q.d_size   <= tl_d_o.a_size;
      if (tl_d_o.a_opcode == Get) begin
        rsp_q.d_opcode   <= AccessAckData;
        rsp_q.d_data     <= {32'h0, mem[tl_d_o.a_address[16:2]]};
        rsp_q.d_user_cap <= tag[tl_d_o.a_address[16:2]];
      end else begin
        mem[tl_d_o.a_address[16:2]] <= tl_d_o.a_data[31:0];
        tag[tl_d_o.a_address[16:2]] <= tl_d_o.a_user_cap;
      end
      if (tl_d_o.a_source == ZSrc) begin
        rsp_q.d_error <= (wlog.size() == err_idx);
        wlog.push_back(tl_d_o.a_address);
        wcyc.push_back(cyc);
        if (tl_d_o.a_opcode != PutFullData || tl_d_o.a_size != 3'd2 ||
            tl_d_o.a_mask != 8'h0F || tl_d_o.a_data != '0 || tl_d_o.a_user_cap) begin
          bad_fields <= bad_fields + 1;
        end
      end
    end
  end

  int          done_cnt = 0;
  int          done_cyc = -1;
  int          h_d_cyc = -1;
  logic [31:0] h_d_data = '0;
  logic        watch = 1'b0;
  int          ready_viol = 0;

  always @(negedge clk_i) begin
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (tl_h_o.d_valid) begin
      h_d_cyc  <= cyc;
      h_d_data <= tl_h_o.d_data[31:0];
    end
    if (watch && tl_h_o.a_ready) ready_viol <= ready_viol + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [16:0] a, input logic [16:0] l, output int s);
    start_i      = 1'b1;
    start_addr_i = a;
    len_words_i  = l;
    s            = cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    forever begin
      @(negedge clk_i);
      if (done_o) break;
      n++;
      if (n >= budget) begin
        check("done_timeout", 64'(done_o), 64'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    watch = 1'b0;
  endtask

  task automatic host_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic cap);
    int n = 0;
    data = 32'hBAD0_BAD0;
    cap  = 1'bx;
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = Get;
    tl_h_i.a_address = addr;
    tl_h_i.a_source  = 8'h01;
    tl_h_i.a_size    = 3'd2;
    tl_h_i.a_mask    = 8'h0F;
    tl_h_i.a_data    = '0;
    forever begin
      @(negedge clk_i);
      if (tl_h_o.a_ready) break;
      n++;
      if (n > 20) begin
        check("read_a_timeout", 64'(tl_h_o.a_ready), 64'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    tl_h_i.a_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (tl_h_o.d_valid) begin
        data = tl_h_o.d_data[31:0];
        cap  = tl_h_o.d_user_cap;
        break;
      end
      n++;
      if (n > 20) begin
        check("read_d_timeout", 64'(tl_h_o.d_valid), 64'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          s, w0, dc;
    logic [31:0] rd;
    logic        rc;

    tl_h_i         = '0;
    tl_h_i.d_ready = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = '0;
      tag[i] = 1'b0;
    end
    for (int i = 'hF0; i <= 'h10F; i++) begin
      mem[i] = 32'hDEAD_BEEF;
      tag[i] = 1'b1;
    end
    for (int i = 'hC00; i < 'hC10; i++) begin
      mem[i] = 32'h1234_5678;
      tag[i] = 1'b1;
    end

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick(1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_d_a_valid", 64'(tl_d_o.a_valid), 64'd0);
    check("rst_h_d_valid", 64'(tl_h_o.d_valid), 64'd0);
    check("rst_h_a_ready", 64'(tl_h_o.a_ready), 64'd1);

    // Basic 4-word run at 0x400
    w0 = wlog.size();
    start_run(17'h400, 17'd4, s);
    watch = 1'b1;
    check("basic_busy_rise", 64'(busy_o), 64'd1);
    wait_done(30);
    check("basic_done_cyc", 64'(done_cyc - s), 64'd7);
    check("basic_nwrites", 64'(wlog.size() - w0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("basic_addr", 64'(wlog[w0+i]), 64'(Base + 32'h400 + 32'(4 * i)));
    end
    check("basic_first_wr_cyc", 64'(wcyc[w0] - s), 64'd2);
    check("basic_busy_fall", 64'(busy_o), 64'd0);
    check("basic_err", 64'(err_o), 64'd0);
    host_read(Base + 32'h400, rd, rc);
    check("basic_rd400", {31'h0, rc, rd}, 64'h0);
    host_read(Base + 32'h40C, rd, rc);
    check("basic_rd40c", {31'h0, rc, rd}, 64'h0);
    host_read(Base + 32'h3FC, rd, rc);
    check("basic_rd3fc", {31'h0, rc, rd}, 64'h1_DEAD_BEEF);
    host_read(Base + 32'h410, rd, rc);
    check("basic_rd410", {31'h0, rc, rd}, 64'h1_DEAD_BEEF);

    // Start in the same cycle as an upstream read handshake: DRAIN waits for its response
    w0 = wlog.size();
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = Get;
    tl_h_i.a_address = Base + 32'h3FC;
    tl_h_i.a_source  = 8'h02;
    tl_h_i.a_size    = 3'd2;
    tl_h_i.a_mask    = 8'h0F;
    start_i      = 1'b1;
    start_addr_i = 17'h800;
    len_words_i  = 17'd2;
    s            = cyc;
    @(posedge clk_i);
    #1;
    start_i        = 1'b0;
    tl_h_i.a_valid = 1'b0;
    watch          = 1'b1;
    wait_done(30);
    check("drain_rsp_cyc", 64'(h_d_cyc - s), 64'd1);
    check("drain_rsp_data", 64'(h_d_data), 64'hDEAD_BEEF);
    check("drain_first_wr_cyc", 64'(wcyc[w0] - s), 64'd3);
    check("drain_done_cyc", 64'(done_cyc - s), 64'd6);
    check("drain_nwrites", 64'(wlog.size() - w0), 64'd2);

    // Pointer wraps at the top of the 128 KiB window
    w0 = wlog.size();
    start_run(17'h1FFF8, 17'd4, s);
    wait_done(30);
    check("wrap_nwrites", 64'(wlog.size() - w0), 64'd4);
    check("wrap_addr0", 64'(wlog[w0]), 64'h0011_FFF8);
    check("wrap_addr1", 64'(wlog[w0+1]), 64'h0011_FFFC);
    check("wrap_addr2", 64'(wlog[w0+2]), 64'h0010_0000);
    check("wrap_addr3", 64'(wlog[w0+3]), 64'h0010_0004);
    check("wrap_err", 64'(err_o), 64'd0);

    // Zero-length run
    w0 = wlog.size();
    start_run(17'h0, 17'd0, s);
    wait_done(10);
    check("len0_done_cyc", 64'(done_cyc - s), 64'd2);
    check("len0_nwrites", 64'(wlog.size() - w0), 64'd0);

    // 16-word run with a second start mid-run that must be ignored
    w0 = wlog.size();
    start_run(17'h1000, 17'd16, s);
    tick(4);
    start_i      = 1'b1;
    start_addr_i = 17'h2000;
    len_words_i  = 17'd3;
    tick(1);
    start_i = 1'b0;
    wait_done(60);
    dc = done_cnt;
    check("ign_done_cyc", 64'(done_cyc - s), 64'd19);
    check("ign_last_addr", 64'(wlog[w0+15]), 64'h0010_103C);
    tick(5);
    check("ign_nwrites", 64'(wlog.size() - w0), 64'd16);
    check("ign_no_extra_done", 64'(done_cnt - dc), 64'd0);
    check("ign_busy_idle", 64'(busy_o), 64'd0);

    // Error on the 3rd write
    w0 = wlog.size();
    err_idx = w0 + 2;
    start_run(17'h1800, 17'd5, s);
    tick(3);
    check("err_before_rsp", 64'(err_o), 64'd0);
    tick(2);
    check("err_after_rsp", 64'(err_o), 64'd1);
    wait_done(30);
    err_idx = -1;
    check("err_done_cyc", 64'(done_cyc - s), 64'd8);
    check("err_nwrites", 64'(wlog.size() - w0), 64'd5);
    check("err_sticky", 64'(err_o), 64'd1);
    start_run(17'h1800, 17'd1, s);
    check("err_cleared", 64'(err_o), 64'd0);
    wait_done(20);
    check("err_next_done_cyc", 64'(done_cyc - s), 64'd4);
    check("err_stays_clear", 64'(err_o), 64'd0);

    // Reset after 5 of 10 writes
    w0 = wlog.size();
    start_run(17'h3000, 17'd10, s);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i);
      #1;
      if (wlog.size() - w0 >= 5) break;
    end
    rst_ni = 1'b0;
    #1;
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_done", 64'(done_o), 64'd0);
    check("mrst_err", 64'(err_o), 64'd0);
    check("mrst_d_a_valid", 64'(tl_d_o.a_valid), 64'd0);
    check("mrst_h_d_valid", 64'(tl_h_o.d_valid), 64'd0);
    tick(2);
    rst_ni = 1'b1;
    tick(2);
    check("mrst_nwrites", 64'(wlog.size() - w0), 64'd5);
    host_read(Base + 32'h3010, rd, rc);
    check("mrst_rd3010", {31'h0, rc, rd}, 64'h0);
    host_read(Base + 32'h3014, rd, rc);
    check("mrst_rd3014", {31'h0, rc, rd}, 64'h1_1234_5678);
    check("mrst_busy_after", 64'(busy_o), 64'd0);

    check("write_fields", 64'(bad_fields), 64'd0);
    check("upstream_ready_blocked", 64'(ready_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
